// File: rtl/bridge_pkg.sv
// bridge_pkg: address map, register bit indices and address decoder shared by the data bus bridge.
package bridge_pkg;
  localparam logic [31:0] CAM_STATUS_ADDR = 32'h0000_1000;
  localparam logic [31:0] CAM_DATA_ADDR   = 32'h0000_1004;
  localparam logic [31:0] CAM_CTRL_ADDR   = 32'h0000_1008;
  localparam logic [31:0] RAM_TOP         = 32'h0000_0FFF;
  localparam int ST_NEMPTY  = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CAPEN   = 3;
  localparam int ST_CNT_LSB = 8;
  localparam int CTRL_CAPEN   = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_FLUSH   = 2;
  typedef enum logic [2:0] {RAM, STATUS, DATA, CTRL, NONE} region_t;
  function automatic region_t decode(input logic [31:0] addr);
    logic [31:0] a;
    a = {addr[31:2], 2'b00};
    return a <= RAM_TOP ? RAM :
           a == CAM_STATUS_ADDR ? STATUS :
           a == CAM_DATA_ADDR ? DATA :
           a == CAM_CTRL_ADDR ? CTRL : NONE;
  endfunction
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous FIFO with push, pop, flush and occupancy count; resets to empty.
module pixel_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_d, wr_q, rd_d, rd_q;
  logic [CW-1:0] count_d, count_q;
  logic push_ok, pop_ok;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign dout  = mem[rd_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  always_comb begin
    wr_d    = flush ? '0 : wr_q + AW'(push_ok);
    rd_d    = flush ? '0 : rd_q + AW'(pop_ok);
    count_d = flush ? '0 : count_q + CW'(push_ok) - CW'(pop_ok);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk)
    if (push_ok && !flush) mem[wr_q] <= din;
endmodule

// File: rtl/data_bus_bridge.sv
// data_bus_bridge: decodes core loads/stores onto the data RAM and camera FIFO registers,
// returning registered ReadData one cycle after the load is sampled.
module data_bus_bridge
  import bridge_pkg::*;
#(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic        write_enable,
  input  logic        mem_read,
  output logic [31:0] ReadData,
  input  logic [15:0] cam_pixel,
  input  logic        cam_valid,
  output logic        cam_ready,
  output logic        cam_irq
);
  localparam int RA = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] read_data_d, read_data_q, status;
  logic [RA-1:0] idx;
  logic [15:0] pix;
  logic [CW-1:0] count;
  logic cap_en_d, cap_en_q, ovf_d, ovf_q;
  logic wr_ctrl, flush, pop, full, empty;
  region_t sel;
  assign sel = decode(ALUResult);
  assign idx = ALUResult[RA+1:2];
  assign wr_ctrl = write_enable && sel == CTRL;
  assign flush = wr_ctrl && WriteData[CTRL_FLUSH];
  assign pop = mem_read && sel == DATA;
  assign cam_ready = cap_en_q && !full;
  assign cam_irq = cap_en_q && !empty;
  assign ReadData = read_data_q;
  pixel_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
    .clk(clk), .reset(reset), .push(cam_valid && cam_ready), .pop(pop), .flush(flush),
    .din(cam_pixel), .dout(pix), .full(full), .empty(empty), .count(count)
  );
  always_comb begin
    status = '0;
    status[ST_NEMPTY] = !empty;
    status[ST_FULL] = full;
    status[ST_OVF] = ovf_q;
    status[ST_CAPEN] = cap_en_q;
    status[ST_CNT_LSB +: CW] = count;
    cap_en_d = wr_ctrl ? WriteData[CTRL_CAPEN] : cap_en_q;
    // a pixel refused for lack of space beats a same-cycle clear
    ovf_d = (cam_valid && cap_en_q && full) || (ovf_q && !(wr_ctrl && WriteData[CTRL_CLR_OVF]));
    read_data_d = !mem_read ? read_data_q :
                  sel == RAM ? ram[idx] :
                  sel == STATUS ? status :
                  sel == DATA && !empty ? {16'h0, pix} : 32'h0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data_q <= '0;
      cap_en_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      read_data_q <= read_data_d;
      cap_en_q    <= cap_en_d;
      ovf_q       <= ovf_d;
    end
  end
  always_ff @(posedge clk)
    if (write_enable && sel == RAM) ram[idx] <= WriteData;
endmodule

// File: tb/tb_data_bus_bridge.sv
// tb_data_bus_bridge: directed stimulus with a ReadData scoreboard checked by an independent monitor.
module tb_data_bus_bridge;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] ALUResult = '0, WriteData = '0, ReadData;
  logic write_enable = 1'b0, mem_read = 1'b0;
  logic [15:0] cam_pixel = '0;
  logic cam_valid = 1'b0, cam_ready, cam_irq;
  logic ld_seen = 1'b0;
  logic [31:0] exp_q[$];
  int total = 0, bad = 0;
  localparam logic [31:0] ST = 32'h1000, DT = 32'h1004, CT = 32'h1008;

  data_bus_bridge dut (
    .clk(clk), .reset(reset), .ALUResult(ALUResult), .WriteData(WriteData),
    .write_enable(write_enable), .mem_read(mem_read), .ReadData(ReadData),
    .cam_pixel(cam_pixel), .cam_valid(cam_valid), .cam_ready(cam_ready), .cam_irq(cam_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge clk) ld_seen <= mem_read && reset;
  always @(negedge clk)
    if (ld_seen) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard: unexpected load result %h", ReadData);
      end else chk("readdata", ReadData, exp_q.pop_front());
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    ALUResult = a;
    WriteData = d;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] e);
    ALUResult = a;
    mem_read = 1'b1;
    exp_q.push_back(e);
    tick();
    mem_read = 1'b0;
  endtask

  task automatic pix(input logic [15:0] v);
    cam_valid = 1'b1;
    cam_pixel = v;
    tick();
    cam_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    chk("reset_readdata", ReadData, 32'h0);
    chk("reset_cam_ready", {31'h0, cam_ready}, 32'h0);
    chk("reset_cam_irq", {31'h0, cam_irq}, 32'h0);
    reset = 1'b1;
    tick();
    // RAM path, read-before-write and address aliasing of low bits
    store(32'h10, 32'hDEADBEEF);
    load(32'h10, 32'hDEADBEEF);
    store(32'hFFC, 32'h0);
    load(32'hFFC, 32'h0);
    ALUResult = 32'h10;
    WriteData = 32'h12345678;
    write_enable = 1'b1;
    mem_read = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    tick();
    write_enable = 1'b0;
    mem_read = 1'b0;
    load(32'h13, 32'h12345678);
    tick();
    chk("readdata_hold", ReadData, 32'h12345678);
    load(32'h2000, 32'h0);
    store(32'h2000, 32'hFFFF_FFFF);
    load(CT, 32'h0);
    // capture three pixels and pop them
    store(CT, 32'h1);
    chk("cam_ready_en", {31'h0, cam_ready}, 32'h1);
    pix(16'h1);
    pix(16'h2);
    pix(16'h3);
    chk("cam_irq_on", {31'h0, cam_irq}, 32'h1);
    load(ST, 32'h0000_0309);
    load(DT, 32'h1);
    load(DT, 32'h2);
    load(DT, 32'h3);
    load(DT, 32'h0);
    load(ST, 32'h0000_0008);
    chk("cam_irq_off", {31'h0, cam_irq}, 32'h0);
    // fill, overflow, clear overflow, drain in order
    for (int i = 0; i < 16; i++) pix(16'(16'h100 + i));
    chk("cam_ready_full", {31'h0, cam_ready}, 32'h0);
    pix(16'hBAD0);
    load(ST, 32'h0000_100F);
    store(CT, 32'h3);
    load(ST, 32'h0000_100B);
    for (int i = 0; i < 16; i++) load(DT, 32'(32'h100 + i));
    load(ST, 32'h0000_0008);
    // simultaneous push and pop from count 4
    for (int i = 0; i < 4; i++) pix(16'(16'h200 + i));
    for (int i = 0; i < 6; i++) begin
      cam_valid = 1'b1;
      cam_pixel = 16'(16'h210 + i);
      ALUResult = DT;
      mem_read = 1'b1;
      exp_q.push_back(i < 4 ? 32'(32'h200 + i) : 32'(32'h210 + i - 4));
      tick();
    end
    cam_valid = 1'b0;
    mem_read = 1'b0;
    load(ST, 32'h0000_0409);
    for (int i = 2; i < 6; i++) load(DT, 32'(32'h210 + i));
    // flush with a same-cycle push that must be discarded
    for (int i = 0; i < 8; i++) pix(16'(16'h300 + i));
    load(ST, 32'h0000_0809);
    cam_valid = 1'b1;
    cam_pixel = 16'h3FF;
    store(CT, 32'h5);
    cam_valid = 1'b0;
    load(ST, 32'h0000_0008);
    chk("cam_ready_after_flush", {31'h0, cam_ready}, 32'h1);
    // reset in the middle of a burst
    for (int i = 0; i < 11; i++) pix(16'(16'h400 + i));
    load(DT, 32'h400);
    tick();
    chk("pre_reset_readdata", ReadData, 32'h400);
    cam_valid = 1'b1;
    cam_pixel = 16'h4FF;
    reset = 1'b0;
    #1;
    chk("mid_reset_readdata", ReadData, 32'h0);
    chk("mid_reset_cam_ready", {31'h0, cam_ready}, 32'h0);
    chk("mid_reset_cam_irq", {31'h0, cam_irq}, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("post_reset_cam_ready", {31'h0, cam_ready}, 32'h0);
    cam_valid = 1'b0;
    load(ST, 32'h0);
    store(CT, 32'h1);
    chk("rearm_cam_ready", {31'h0, cam_ready}, 32'h1);
    tick();
    tick();
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
